player_motion: RTL and testbench

Parametrised horizontal player-position controller for the game datapath. It sits between the button inputs and the VGA sprite renderer. It holds the player's X coordinate in a configurable field and steps it left or right at a divided frame-rate tick, clamped to screen bounds. A start/pause state machine controls it and it reports wall contact and update strobes.

---
 rtl/game_pkg.sv | 37 +++
 rtl/player_motion_if.sv | 32 +++
 rtl/player_motion_tick_gen.sv | 45 ++++
 rtl/player_motion.sv | 172 +++++++++++++++++
 tb/tb_player_motion.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game datapath: FSM state encodings, the
// direction decode used by motion controllers, screen geometry and the
// default movement-tick divider for a 50 MHz clock at 60 Hz.
// No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  localparam int SCREEN_W     = 640;
  localparam int X_MIN_DEF    = 0;
  localparam int X_MAX_DEF    = SCREEN_W - 1;
  localparam int X_START_DEF  = SCREEN_W / 2;
  localparam int CLK_HZ       = 50_000_000;
  localparam int FRAME_HZ     = 60;
  localparam int TICK_DIV_DEF = CLK_HZ / FRAME_HZ;

  // Both or neither button pressed means no motion request.
  function automatic dir_e decode_dir(input logic right, input logic left);
    if (right && !left) return DIR_RIGHT;
    if (left && !right) return DIR_LEFT;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/player_motion_if.sv
// -----------------------------------------------------------------------------
// player_motion_if
// Button / position bundle between the input logic and player_motion.
//   right, left, start, pause : button levels (driven by master)
//   x_val                     : current player X (X_W bits)
//   running, at_min, at_max   : status flags
//   moved                     : one-cycle strobe when x_val changed
// master drives the buttons, slave (player_motion) drives the status.
// -----------------------------------------------------------------------------
interface player_motion_if #(
  parameter int X_W = 10
);
  logic           right;
  logic           left;
  logic           start;
  logic           pause;
  logic [X_W-1:0] x_val;
  logic           running;
  logic           at_min;
  logic           at_max;
  logic           moved;

  modport master (
    output right, left, start, pause,
    input  x_val, running, at_min, at_max, moved
  );

  modport slave (
    input  right, left, start, pause,
    output x_val, running, at_min, at_max, moved
  );
endinterface

// File: rtl/player_motion_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Movement-tick divider. Counts 0..TICK_DIV-1 while enabled and wraps; the
// tick is high on the cycle the count sits at TICK_DIV-1 and enable is high.
// With enable low the count is frozen; clear forces it back to 0.
// Ports:
//   clk     : clock
//   rst     : synchronous active-low reset
//   en_i    : advance the counter this cycle
//   clr_i   : force counter to 0 (wins over en_i)
//   tick_o  : one-cycle movement tick
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
// Horizontal player-position controller. An IDLE/RUN/PAUSED state machine
// gates a movement tick; on each tick the X position steps right or left by
// the current step and is clamped to [X_MIN, X_MAX].
// Optional feature macro: PLAYER_MOTION_ACCEL_EN -- when defined, the step
// grows by 1 per tick while the same direction is held (up to STEP_MAX) and
// drops back to STEP on release, reversal, both buttons, wall clamp, pause
// entry or reset. When undefined the step is fixed at STEP.
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : player_motion_if.slave (buttons in; x_val, running, at_min,
//          at_max, moved out)
// -----------------------------------------------------------------------------
module player_motion
  import game_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int X_MIN    = X_MIN_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int X_START  = X_START_DEF,
  parameter int STEP     = 4,
  parameter int STEP_MAX = 16,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  player_motion_if.slave  bus
);

  // Arithmetic width: one bit over the wider of x and the largest step, so
  // x+step never wraps and the step register can hold its ceiling.
  localparam int STEP_CEIL = (STEP_MAX > STEP) ? STEP_MAX : STEP;
  localparam int STEP_BW   = $clog2(STEP_CEIL + 1);
  localparam int CALC_W    = ((X_W > STEP_BW) ? X_W : STEP_BW) + 1;

  localparam logic [CALC_W-1:0] STEP_C   = CALC_W'(STEP);
  localparam logic [CALC_W-1:0] X_MIN_C  = CALC_W'(X_MIN);
  localparam logic [CALC_W-1:0] X_MAX_C  = CALC_W'(X_MAX);
  localparam logic [X_W-1:0]    X_START_X = X_W'(X_START);

  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic              moved_q;
  logic              tick;
  logic              tick_en;
  logic              tick_clr;
  dir_e              dir_now;
  logic              clamp;
  logic [CALC_W-1:0] step_eff;
  logic [CALC_W-1:0] x_ext;

`ifdef PLAYER_MOTION_ACCEL_EN
  localparam logic [CALC_W-1:0] STEP_MAX_C = CALC_W'(STEP_MAX);
  logic [CALC_W-1:0] step_q, step_d;
  dir_e              dir_q, dir_d;
`endif

  // Pause masks the counter as well as the tick, so a pause landing on the
  // tick cycle suppresses that move and keeps the count where it was.
  assign tick_en  = (state_q == RUN) && !bus.pause;
  assign tick_clr = (state_q == IDLE);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (tick_en),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.pause) state_d = PAUSED;
      PAUSED:  if (!bus.pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dir_now  = decode_dir(bus.right, bus.left);
    x_ext    = CALC_W'(x_q);
    step_eff = STEP_C;
    x_d      = x_q;
    clamp    = 1'b0;

`ifdef PLAYER_MOTION_ACCEL_EN
    step_d = step_q;
    dir_d  = dir_q;
    // Same single direction as the previous tick: grow the step, saturating.
    if ((dir_now != DIR_NONE) && (dir_now == dir_q)) begin
      step_eff = (step_q >= STEP_MAX_C) ? STEP_MAX_C : step_q + 1'b1;
    end
`endif

    if (state_q == IDLE) begin
      x_d = X_START_X;
    end else if (tick) begin
      unique case (dir_now)
        DIR_RIGHT: begin
          if (x_ext + step_eff > X_MAX_C) begin
            x_d   = X_MAX_C[X_W-1:0];
            clamp = 1'b1;
          end else begin
            x_d = X_W'(x_ext + step_eff);
          end
        end
        DIR_LEFT: begin
          // Compare before subtracting so the result can never underflow.
          if (x_ext < X_MIN_C + step_eff) begin
            x_d   = X_MIN_C[X_W-1:0];
            clamp = 1'b1;
          end else begin
            x_d = X_W'(x_ext - step_eff);
          end
        end
        default: x_d = x_q;
      endcase
    end

`ifdef PLAYER_MOTION_ACCEL_EN
    if ((state_q == IDLE) || ((state_q == RUN) && bus.pause)) begin
      step_d = STEP_C;
      dir_d  = DIR_NONE;
    end else if (tick) begin
      if ((dir_now == DIR_NONE) || clamp) begin
        step_d = STEP_C;
        dir_d  = DIR_NONE;
      end else begin
        step_d = step_eff;
        dir_d  = dir_now;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= X_START_X;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      moved_q <= (x_d != x_q);
    end
  end

`ifdef PLAYER_MOTION_ACCEL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_q <= STEP_C;
      dir_q  <= DIR_NONE;
    end else begin
      step_q <= step_d;
      dir_q  <= dir_d;
    end
  end
`endif

  assign bus.x_val   = x_q;
  assign bus.running = (state_q == RUN);
  assign bus.at_min  = (x_q == X_MIN_C[X_W-1:0]);
  assign bus.at_max  = (x_q == X_MAX_C[X_W-1:0]);
  assign bus.moved   = moved_q;

endmodule

// File: tb/tb_player_motion.sv
// -----------------------------------------------------------------------------
// tb_player_motion
// Scoreboard bench for player_motion. Stimulus pushes the expected x_val of
// every move into a queue; a monitor pops and compares on each moved strobe.
// Held ticks, flags and pause/reset timing are checked directly.
// -----------------------------------------------------------------------------
module tb_player_motion;

  localparam int X_W      = 10;
  localparam int X_MIN    = 0;
  localparam int X_MAX    = 639;
  localparam int X_START  = 320;
  localparam int STEP     = 4;
  localparam int STEP_MAX = 16;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  player_motion_if #(.X_W(X_W)) bus ();

  player_motion #(
    .X_W      (X_W),
    .X_MIN    (X_MIN),
    .X_MAX    (X_MAX),
    .X_START  (X_START),
    .STEP     (STEP),
    .STEP_MAX (STEP_MAX),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: every moved strobe must match the next queued position.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.moved === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_moved: got strobe with x_val=%0d, want no strobe", bus.x_val);
        end else begin
          int w;
          w = exp_q.pop_front();
          check("moved_x", 32'(bus.x_val), 32'(w));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  // Called at the negedge just after a tick edge; returns at the next one.
  task automatic do_tick(input logic r, input logic l, input int want, input bit mv);
    bus.right = r;
    bus.left  = l;
    if (mv) exp_q.push_back(want);
    repeat (TICK_DIV) @(negedge clk);
    if (!mv) begin
      check("hold_moved", 32'(bus.moved), 32'd0);
      check("hold_x", 32'(bus.x_val), 32'(want));
    end
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("running_after_start", 32'(bus.running), 32'd1);
  endtask

  initial begin
    bus.right = 1'b0;
    bus.left  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(bus.x_val), 32'd320);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_moved", 32'(bus.moved), 32'd0);
    check("rst_at_min", 32'(bus.at_min), 32'd0);
    check("rst_at_max", 32'(bus.at_max), 32'd0);

    // Idle with right held: nothing moves.
    rst = 1'b1;
    bus.right = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_state", {bus.x_val, bus.running, bus.moved}, {10'd320, 2'b00});
    end

`ifndef PLAYER_MOTION_ACCEL_EN
    start_run();
    do_tick(1'b1, 1'b0, 324, 1'b1);
    do_tick(1'b1, 1'b0, 328, 1'b1);
    do_tick(1'b1, 1'b0, 332, 1'b1);
    do_tick(1'b0, 1'b1, 328, 1'b1);
    do_tick(1'b1, 1'b1, 328, 1'b0);
    do_tick(1'b0, 1'b0, 328, 1'b0);

    // Right wall.
    for (int v = 332; v <= 636; v += 4) do_tick(1'b1, 1'b0, v, 1'b1);
    check("at_max_636", 32'(bus.at_max), 32'd0);
    do_tick(1'b1, 1'b0, 639, 1'b1);
    check("at_max_639", 32'(bus.at_max), 32'd1);
    do_tick(1'b1, 1'b0, 639, 1'b0);
    check("at_max_hold", 32'(bus.at_max), 32'd1);
    check("at_min_right", 32'(bus.at_min), 32'd0);

    // Left wall.
    for (int v = 635; v >= 3; v -= 4) do_tick(1'b0, 1'b1, v, 1'b1);
    check("at_min_3", 32'(bus.at_min), 32'd0);
    do_tick(1'b0, 1'b1, 0, 1'b1);
    check("at_min_0", 32'(bus.at_min), 32'd1);
    do_tick(1'b0, 1'b1, 0, 1'b0);
    check("at_min_hold", 32'(bus.at_min), 32'd1);

    // Pause two cycles into a tick period; resume finishes the remaining count.
    bus.left  = 1'b0;
    bus.right = 1'b1;
    repeat (2) @(negedge clk);
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("paused_state", {bus.x_val, bus.running, bus.moved}, {10'd0, 2'b00});
    end
    exp_q.push_back(4);
    bus.pause = 1'b0;
    @(negedge clk);
    check("resume_running", 32'(bus.running), 32'd1);
    check("resume_early1", 32'(bus.moved), 32'd0);
    @(negedge clk);
    check("resume_early2", 32'(bus.moved), 32'd0);
    @(negedge clk);
    check("resume_tick", 32'(bus.moved), 32'd1);

    // Walk to 500, then reset mid-count.
    for (int v = 8; v <= 500; v += 4) do_tick(1'b1, 1'b0, v, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_x", 32'(bus.x_val), 32'd320);
    check("midrst_running", 32'(bus.running), 32'd0);
    check("midrst_moved", 32'(bus.moved), 32'd0);
    exp_q.push_back(324);
    start_run();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("restart_early", 32'(bus.moved), 32'd0);
    end
    @(negedge clk);
    check("restart_tick", 32'(bus.moved), 32'd1);
`else
    start_run();
    do_tick(1'b1, 1'b0, 324, 1'b1);
    do_tick(1'b1, 1'b0, 329, 1'b1);
    do_tick(1'b1, 1'b0, 335, 1'b1);
    do_tick(1'b1, 1'b0, 342, 1'b1);
    do_tick(1'b0, 1'b1, 338, 1'b1);
    do_tick(1'b0, 1'b1, 333, 1'b1);
    do_tick(1'b0, 1'b0, 333, 1'b0);
    do_tick(1'b1, 1'b0, 337, 1'b1);
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
